// File: rtl/alu_byte_sequencer_pkg.sv
// Shared constants for the byte-serial ALU sequencer: widths, ALU op codes, flag codes, FSM states.
// Optional feature macro used elsewhere: ALU_SEQ_CARRY_IN_EN (adds a byte-0 carry/borrow input).
package alu_byte_sequencer_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int CONTROL_WIDTH = 4;
    localparam int FLAG_WIDTH    = 2;

    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A          = 4'd0;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_B          = 4'd1;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_PLUS_B   = 4'd2;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_MINUS_B  = 4'd3;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_AND_B    = 4'd4;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_OR_B     = 4'd5;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_XOR_B    = 4'd6;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_NOT_A      = 4'd7;

    localparam logic [FLAG_WIDTH-1:0] DEFAULT_FLAG  = 2'd0;
    localparam logic [FLAG_WIDTH-1:0] OVERFLOW_FLAG = 2'd1;
    localparam logic [FLAG_WIDTH-1:0] ZERO_FLAG     = 2'd2;
    localparam logic [FLAG_WIDTH-1:0] NEGATIVE_FLAG = 2'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_arith(input logic [CONTROL_WIDTH-1:0] op);
        return (op == OUTPUT_A_PLUS_B) || (op == OUTPUT_A_MINUS_B);
    endfunction

    // Carry/borrow outranks zero: a wrapped 0x0000 from an add is still an overflow.
    function automatic logic [FLAG_WIDTH-1:0] word_flag(input logic [CONTROL_WIDTH-1:0] op,
                                                        input logic                     cb,
                                                        input logic                     nonzero);
        if (op == OUTPUT_A_PLUS_B && cb)
            return OVERFLOW_FLAG;
        else if (op == OUTPUT_A_MINUS_B && cb)
            return NEGATIVE_FLAG;
        else if (!nonzero)
            return ZERO_FLAG;
        else
            return DEFAULT_FLAG;
    endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Request/result bus of the byte-serial ALU sequencer; master = requester/consumer, slave = sequencer.
// With ALU_SEQ_CARRY_IN_EN defined the bus also carries carry_borrow_i (byte-0 carry/borrow).
interface alu_byte_sequencer_if
    import alu_byte_sequencer_pkg::*;
#(
    parameter int NUM_BYTES = 2
) ();

    localparam int W = DATA_WIDTH * NUM_BYTES;

    logic                     start_valid_i;
    logic                     start_ready_o;
    logic [CONTROL_WIDTH-1:0] op_i;
    logic [W-1:0]             a_i;
    logic [W-1:0]             b_i;
`ifdef ALU_SEQ_CARRY_IN_EN
    logic                     carry_borrow_i;
`endif
    logic [W-1:0]             result_o;
    logic                     carry_borrow_o;
    logic [FLAG_WIDTH-1:0]    status_flag_o;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic                     busy_o;

`ifdef ALU_SEQ_CARRY_IN_EN
    modport master (
        output start_valid_i, op_i, a_i, b_i, carry_borrow_i, result_ready_i,
        input  start_ready_o, result_o, carry_borrow_o, status_flag_o, result_valid_o, busy_o
    );
    modport slave (
        input  start_valid_i, op_i, a_i, b_i, carry_borrow_i, result_ready_i,
        output start_ready_o, result_o, carry_borrow_o, status_flag_o, result_valid_o, busy_o
    );
`else
    modport master (
        output start_valid_i, op_i, a_i, b_i, result_ready_i,
        input  start_ready_o, result_o, carry_borrow_o, status_flag_o, result_valid_o, busy_o
    );
    modport slave (
        input  start_valid_i, op_i, a_i, b_i, result_ready_i,
        output start_ready_o, result_o, carry_borrow_o, status_flag_o, result_valid_o, busy_o
    );
`endif

endinterface

// File: rtl/alu_byte_sequencer_alu.sv
// Combinational 8-bit ALU shared by the sequencer; carry (add) / borrow (sub) in and out,
// carry out is 0 for every non-arithmetic op.
module alu_byte_sequencer_alu
    import alu_byte_sequencer_pkg::*;
(
    input  logic [CONTROL_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]    i_a,
    input  logic [DATA_WIDTH-1:0]    i_b,
    input  logic                     i_cin,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic                     o_cout
);

    logic [DATA_WIDTH:0] w_wide;

    // Subtraction wraps in DATA_WIDTH+1 bits, so the top bit is the borrow.
    always_comb begin
        w_wide   = '0;
        o_result = '0;
        o_cout   = 1'b0;
        case (i_op)
            OUTPUT_A:        o_result = i_a;
            OUTPUT_B:        o_result = i_b;
            OUTPUT_A_PLUS_B: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};
                o_result = w_wide[DATA_WIDTH-1:0];
                o_cout   = w_wide[DATA_WIDTH];
            end
            OUTPUT_A_MINUS_B: begin
                w_wide   = {1'b0, i_a} - {1'b0, i_b} - {{DATA_WIDTH{1'b0}}, i_cin};
                o_result = w_wide[DATA_WIDTH-1:0];
                o_cout   = w_wide[DATA_WIDTH];
            end
            OUTPUT_A_AND_B:  o_result = i_a & i_b;
            OUTPUT_A_OR_B:   o_result = i_a | i_b;
            OUTPUT_A_XOR_B:  o_result = i_a ^ i_b;
            OUTPUT_NOT_A:    o_result = ~i_a;
            default:         o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Runs one NUM_BYTES-wide ALU operation LSB byte first through a single 8-bit ALU, chaining carry/borrow.
// Define ALU_SEQ_CARRY_IN_EN to use the bus carry_borrow_i as byte-0 carry/borrow (ADC/SBB).
module alu_byte_sequencer
    import alu_byte_sequencer_pkg::*;
#(
    parameter int NUM_BYTES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    alu_byte_sequencer_if.slave bus
);

    localparam int               CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    seq_state_e                           r_state, w_next_state;
    logic [CNT_W-1:0]                     r_cnt;
    logic [CONTROL_WIDTH-1:0]             r_op;
    logic [NUM_BYTES-1:0][DATA_WIDTH-1:0] r_a, r_b, r_result, w_word;
    logic                                 r_chain, r_carry;
    logic [FLAG_WIDTH-1:0]                r_flag;
    logic                                 w_accept, w_last, w_cin0;
    logic                                 w_start_ready, w_result_valid, w_busy;
    logic                                 w_alu_cin, w_alu_cout;
    logic [DATA_WIDTH-1:0]                w_alu_res;

`ifdef ALU_SEQ_CARRY_IN_EN
    logic r_cin0;
    assign w_cin0 = r_cin0;
`else
    assign w_cin0 = 1'b0;
`endif

    assign w_accept  = (r_state == SEQ_IDLE) && bus.start_valid_i;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_alu_cin = is_arith(r_op) && ((r_cnt == '0) ? w_cin0 : r_chain);

    alu_byte_sequencer_alu u_eight_bit_alu (
        .i_op     (r_op),
        .i_a      (r_a[r_cnt]),
        .i_b      (r_b[r_cnt]),
        .i_cin    (w_alu_cin),
        .o_result (w_alu_res),
        .o_cout   (w_alu_cout)
    );

    // The final byte is not registered yet when the flag is taken, so splice it in here.
    always_comb begin
        w_word        = r_result;
        w_word[r_cnt] = w_alu_res;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= SEQ_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_start_ready  = 1'b0;
        w_result_valid = 1'b0;
        w_busy         = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_start_ready = 1'b1;
                if (bus.start_valid_i) w_next_state = SEQ_EXEC;
            end
            SEQ_EXEC: begin
                w_busy = 1'b1;
                if (w_last) w_next_state = SEQ_DONE;
            end
            SEQ_DONE: begin
                w_busy         = 1'b1;
                w_result_valid = 1'b1;
                if (bus.result_ready_i) w_next_state = SEQ_IDLE;
            end
            default: w_next_state = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_chain  <= 1'b0;
            r_carry  <= 1'b0;
            r_flag   <= DEFAULT_FLAG;
`ifdef ALU_SEQ_CARRY_IN_EN
            r_cin0   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op    <= bus.op_i;
            r_a     <= bus.a_i;
            r_b     <= bus.b_i;
            r_cnt   <= '0;
            r_chain <= 1'b0;
`ifdef ALU_SEQ_CARRY_IN_EN
            r_cin0  <= bus.carry_borrow_i;
`endif
        end else if (r_state == SEQ_EXEC) begin
            r_result[r_cnt] <= w_alu_res;
            r_chain         <= w_alu_cout;
            if (w_last) begin
                r_carry <= w_alu_cout;
                r_flag  <= word_flag(r_op, w_alu_cout, |w_word);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.start_ready_o  = w_start_ready;
    assign bus.result_valid_o = w_result_valid;
    assign bus.busy_o         = w_busy;
    assign bus.result_o       = r_result;
    assign bus.carry_borrow_o = r_carry;
    assign bus.status_flag_o  = r_flag;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Scoreboard bench for alu_byte_sequencer (NUM_BYTES=2): directed ops, back-pressure, mid-op reset,
// and ADC/SBB vectors when ALU_SEQ_CARRY_IN_EN is defined.
module tb_alu_byte_sequencer;
    import alu_byte_sequencer_pkg::*;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] res;
        logic         cb;
        logic [1:0]   flag;
        int unsigned  t_acc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic        prev_valid = 1'b0;
`ifdef ALU_SEQ_CARRY_IN_EN
    logic        tb_cin = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_byte_sequencer_if #(.NUM_BYTES(NB)) bus ();

    alu_byte_sequencer #(.NUM_BYTES(NB)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every new result presentation is matched against the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (bus.result_valid_o && !prev_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got result 0x%0h, expected no output", bus.result_o);
            end else begin
                mon_e = q.pop_front();
                chk("result", 32'(bus.result_o), 32'(mon_e.res));
                chk("carry_borrow", 32'(bus.carry_borrow_o), 32'(mon_e.cb));
                chk("status_flag", 32'(bus.status_flag_o), 32'(mon_e.flag));
                chk("latency", cyc - mon_e.t_acc, 32'(NB + 1));
            end
        end
        prev_valid = bus.result_valid_o;
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] er, input logic ecb, input logic [1:0] ef);
        int waited = 0;
        @(negedge clk);
        bus.op_i          = op;
        bus.a_i           = a;
        bus.b_i           = b;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.carry_borrow_i = tb_cin;
`endif
        bus.start_valid_i = 1'b1;
        while (!bus.start_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.start_ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got start_ready_o=0 for 50 cycles, expected 1");
        end else if (push) begin
            q.push_back('{res: er, cb: ecb, flag: ef, t_acc: cyc});
        end
        @(posedge clk);
        #1;
        // Scramble operands after accept: they must not affect the running op.
        bus.start_valid_i = 1'b0;
        bus.a_i           = ~a;
        bus.b_i           = ~b;
        bus.op_i          = OUTPUT_NOT_A;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.carry_borrow_i = ~tb_cin;
`endif
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !bus.start_ready_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 32'(bus.start_ready_o), 32'd1);
        chk({tag, "_result_valid"}, 32'(bus.result_valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_result"}, 32'(bus.result_o), 32'd0);
        chk({tag, "_carry_borrow"}, 32'(bus.carry_borrow_o), 32'd0);
        chk({tag, "_flag"}, 32'(bus.status_flag_o), 32'(DEFAULT_FLAG));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start_valid_i  = 1'b0;
        bus.op_i           = '0;
        bus.a_i            = '0;
        bus.b_i            = '0;
        bus.result_ready_i = 1'b1;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.carry_borrow_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        issue(OUTPUT_A_PLUS_B,  16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, DEFAULT_FLAG);
        issue(OUTPUT_A_PLUS_B,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, OVERFLOW_FLAG);
        issue(OUTPUT_A_MINUS_B, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b1, NEGATIVE_FLAG);
        issue(OUTPUT_A_MINUS_B, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, ZERO_FLAG);
        issue(OUTPUT_A_MINUS_B, 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b0, DEFAULT_FLAG);
        issue(OUTPUT_A_PLUS_B,  16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, OVERFLOW_FLAG);
        issue(OUTPUT_A_AND_B,   16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, DEFAULT_FLAG);
        issue(OUTPUT_A_XOR_B,   16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 1'b0, ZERO_FLAG);
        issue(OUTPUT_A_OR_B,    16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, DEFAULT_FLAG);
        drain();

        // Back-pressure: hold the result for 5 cycles while a competing request is offered.
        bus.result_ready_i = 1'b0;
        issue(OUTPUT_A_PLUS_B, 16'h1111, 16'h2222, 1'b1, 16'h3333, 1'b0, DEFAULT_FLAG);
        n = 0;
        while (!bus.result_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", 32'(bus.result_valid_o), 32'd1);
        bus.op_i          = OUTPUT_A_OR_B;
        bus.a_i           = 16'hFFFF;
        bus.b_i           = 16'hFFFF;
        bus.start_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", 32'(bus.result_o), 32'h3333);
            chk("hold_flag", 32'(bus.status_flag_o), 32'(DEFAULT_FLAG));
            chk("hold_start_ready", 32'(bus.start_ready_o), 32'd0);
            chk("hold_result_valid", 32'(bus.result_valid_o), 32'd1);
            chk("hold_busy", 32'(bus.busy_o), 32'd1);
        end
        bus.start_valid_i  = 1'b0;
        bus.result_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("release_start_ready", 32'(bus.start_ready_o), 32'd1);
        chk("release_result_valid", 32'(bus.result_valid_o), 32'd0);
        chk("release_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        chk("idle_result_kept", 32'(bus.result_o), 32'h3333);

        issue(OUTPUT_A_MINUS_B, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, NEGATIVE_FLAG);
        drain();

        // Reset while byte 1 is executing; the discarded op must produce no result.
        issue(OUTPUT_A_PLUS_B, 16'h0F0F, 16'h0101, 1'b0, 16'h0000, 1'b0, DEFAULT_FLAG);
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(OUTPUT_A_PLUS_B, 16'h0102, 16'h0304, 1'b1, 16'h0406, 1'b0, DEFAULT_FLAG);
        drain();

`ifdef ALU_SEQ_CARRY_IN_EN
        tb_cin = 1'b1;
        issue(OUTPUT_A_PLUS_B,  16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, DEFAULT_FLAG);
        issue(OUTPUT_A_MINUS_B, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, NEGATIVE_FLAG);
        issue(OUTPUT_A_AND_B,   16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, DEFAULT_FLAG);
        tb_cin = 1'b0;
        issue(OUTPUT_A_PLUS_B,  16'h00FF, 16'h0000, 1'b1, 16'h00FF, 1'b0, DEFAULT_FLAG);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
